// File: rtl/alu_cmd_master_pkg.sv
// Shared types and helpers for the ALU command master.
// Latency: n/a (types, constants and a combinational function only).
// Backpressure: n/a.
//
// Contents: opcode enum, FSM state enum, cmd_data field layout, tag queue
// sizing, and the 9-bit expected-result function used for response checks.
package alu_cmd_master_pkg;

    localparam int OP_W   = 2;
    localparam int OPND_W = 4;
    localparam int RES_W  = 9;
    localparam int CMD_W  = OP_W + 2 * OPND_W;

    // cmd_data layout: [9:8] op, [7:4] B, [3:0] A
    localparam int CMD_A_LSB  = 0;
    localparam int CMD_B_LSB  = CMD_A_LSB + OPND_W;
    localparam int CMD_OP_LSB = CMD_B_LSB + OPND_W;

    localparam int TAGQ_DEPTH = 8;
    localparam int TAGQ_CNT_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FAULT  = 2'd2
    } mst_state_e;

    // Reference result for a tagged command. Subtraction wraps mod 512;
    // division by zero yields 0 here but is never compared (see alu_skip_check).
    function automatic logic [RES_W-1:0] alu_expected(
        input logic [OP_W-1:0]   op,
        input logic [OPND_W-1:0] a,
        input logic [OPND_W-1:0] b
    );
        logic [RES_W-1:0] ea;
        logic [RES_W-1:0] eb;
        logic [RES_W-1:0] r;
        ea = RES_W'(a);
        eb = RES_W'(b);
        case (op)
            OP_ADD:  r = ea + eb;
            OP_SUB:  r = ea - eb;
            OP_MUL:  r = ea * eb;
            OP_DIV:  r = (b == '0) ? '0 : (ea / eb);
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic alu_skip_check(
        input logic [OP_W-1:0]   op,
        input logic [OPND_W-1:0] b
    );
        return (op == OP_DIV) && (b == '0);
    endfunction

endpackage

// File: rtl/alu_tag_queue.sv
// In-order tag FIFO holding issued commands until their responses return.
// Latency: push visible at head the cycle after; head is combinational from storage.
// Backpressure: push ignored when full, pop ignored when empty; caller gates both.
//
// Ports: clk/reset, i_push + i_push_dat, i_pop, o_head (oldest entry), o_count.
// DEPTH must be a power of two so the pointers wrap naturally.
module alu_tag_queue #(
    parameter int DEPTH = 8,
    parameter int W     = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_push,
    input  logic [W-1:0]                 i_push_dat,
    input  logic                         i_pop,
    output logic [W-1:0]                 o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign w_push_ok = i_push && (r_count != CNT_W'(DEPTH));
    assign w_pop_ok  = i_pop  && (r_count != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_push_dat;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/alu_cmd_master.sv
// Issues host ALU commands with a credit limit, checks returned results in order.
// Latency: host->cmd 1 cycle; rsp->out 1 cycle.
// Backpressure: valid/ready on all three sides; rsp_ready follows out_ready.
//
// Ports: host_* (request in), cmd_* (command out), rsp_* (result in),
// out_* (checked result out), outstanding count, sticky timeout/proto/mismatch flags.
import alu_cmd_master_pkg::*;

module alu_cmd_master #(
    parameter int MAX_OUTSTANDING = 7,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             host_valid,
    output logic             host_ready,
    input  logic [1:0]       host_op,
    input  logic [3:0]       host_a,
    input  logic [3:0]       host_b,
    output logic [9:0]       cmd_data,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    input  logic [8:0]       rsp_data,
    input  logic             rsp_valid,
    output logic             rsp_ready,
    output logic [8:0]       out_result,
    output logic [1:0]       out_op,
    output logic             out_mismatch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       outstanding,
    output logic             timeout_err,
    output logic             proto_err,
    output logic             mismatch_err
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic                   r_cmd_valid;
    logic [CMD_W-1:0]       r_cmd_data;
    logic                   r_out_valid;
    logic                   r_out_mismatch;
    logic [RES_W-1:0]       r_out_result;
    logic [OP_W-1:0]        r_out_op;
    logic                   r_timeout_err;
    logic                   r_proto_err;
    logic                   r_mismatch_err;
    logic [TMR_W-1:0]       r_timer;
    mst_state_e             r_state;
    mst_state_e             w_state_next;

    logic [CMD_W-1:0]       w_q_head;
    logic [TAGQ_CNT_W-1:0]  w_q_count;
    logic [TAGQ_CNT_W-1:0]  w_q_count_next;
    logic [TAGQ_CNT_W-1:0]  w_inflight;
    logic                   w_host_ready;
    logic                   w_rsp_ready;
    logic                   w_host_fire;
    logic                   w_cmd_fire;
    logic                   w_rsp_fire;
    logic                   w_rsp_tagged;
    logic                   w_rsp_orphan;
    logic [OP_W-1:0]        w_tag_op;
    logic [OPND_W-1:0]      w_tag_a;
    logic [OPND_W-1:0]      w_tag_b;
    logic [RES_W-1:0]       w_expected;
    logic                   w_mismatch;
    logic                   w_tmr_clear;
    logic                   w_timeout_set;

    // A command parked in the output register is counted against the credit
    // limit; otherwise a new host request accepted while it drains would push
    // the outstanding count one past MAX_OUTSTANDING.
    assign w_inflight   = w_q_count + TAGQ_CNT_W'(r_cmd_valid);
    assign w_host_ready = !reset && (!r_cmd_valid || cmd_ready)
                          && (w_inflight < TAGQ_CNT_W'(MAX_OUTSTANDING))
                          && (r_state != ST_FAULT);
    assign w_rsp_ready  = !reset && (!r_out_valid || out_ready);

    assign w_host_fire  = host_valid && w_host_ready;
    assign w_cmd_fire   = r_cmd_valid && cmd_ready;
    assign w_rsp_fire   = rsp_valid && w_rsp_ready;
    assign w_rsp_tagged = w_rsp_fire && (w_q_count != '0);
    assign w_rsp_orphan = w_rsp_fire && (w_q_count == '0);

    assign w_q_count_next = w_q_count + TAGQ_CNT_W'(w_cmd_fire) - TAGQ_CNT_W'(w_rsp_tagged);

    alu_tag_queue #(
        .DEPTH (TAGQ_DEPTH),
        .W     (CMD_W)
    ) u_tag_q (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_cmd_fire),
        .i_push_dat (r_cmd_data),
        .i_pop      (w_rsp_tagged),
        .o_head     (w_q_head),
        .o_count    (w_q_count)
    );

    assign w_tag_op   = w_q_head[CMD_OP_LSB +: OP_W];
    assign w_tag_b    = w_q_head[CMD_B_LSB  +: OPND_W];
    assign w_tag_a    = w_q_head[CMD_A_LSB  +: OPND_W];
    assign w_expected = alu_expected(w_tag_op, w_tag_a, w_tag_b);
    assign w_mismatch = !alu_skip_check(w_tag_op, w_tag_b) && (rsp_data != w_expected);

    // Timer saturates at TIMEOUT_CYCLES; the flag is raised on the edge it gets there.
    assign w_tmr_clear   = w_rsp_fire || (w_q_count == '0);
    assign w_timeout_set = !w_tmr_clear && (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_tmr_clear) begin
            r_timer <= '0;
        end else if (r_timer != TMR_W'(TIMEOUT_CYCLES)) begin
            r_timer <= r_timer + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Fault entry uses the same-cycle set conditions so state and flag move together.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FAULT: w_state_next = ST_FAULT;
            default: begin
                if (w_timeout_set || w_rsp_orphan) begin
                    w_state_next = ST_FAULT;
                end else if (w_q_count_next != '0) begin
                    w_state_next = ST_ACTIVE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd_valid    <= 1'b0;
            r_cmd_data     <= '0;
            r_out_valid    <= 1'b0;
            r_out_result   <= '0;
            r_out_op       <= '0;
            r_out_mismatch <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_proto_err    <= 1'b0;
            r_mismatch_err <= 1'b0;
        end else begin
            if (w_host_fire) begin
                r_cmd_data  <= {host_op, host_b, host_a};
                r_cmd_valid <= 1'b1;
            end else if (w_cmd_fire) begin
                r_cmd_valid <= 1'b0;
            end

            if (w_rsp_tagged) begin
                r_out_valid    <= 1'b1;
                r_out_result   <= rsp_data;
                r_out_op       <= w_tag_op;
                r_out_mismatch <= w_mismatch;
            end else if (r_out_valid && out_ready) begin
                r_out_valid    <= 1'b0;
                r_out_mismatch <= 1'b0;
            end

            if (w_rsp_tagged && w_mismatch) r_mismatch_err <= 1'b1;
            if (w_rsp_orphan)               r_proto_err    <= 1'b1;
            if (w_timeout_set)              r_timeout_err  <= 1'b1;
        end
    end

    assign host_ready   = w_host_ready;
    assign rsp_ready    = w_rsp_ready;
    assign cmd_valid    = r_cmd_valid;
    assign cmd_data     = r_cmd_data;
    assign out_valid    = r_out_valid;
    assign out_result   = r_out_result;
    assign out_op       = r_out_op;
    assign out_mismatch = r_out_mismatch;
    assign outstanding  = w_q_count[2:0];
    assign timeout_err  = r_timeout_err;
    assign proto_err    = r_proto_err;
    assign mismatch_err = r_mismatch_err;

endmodule

// File: tb/tb_alu_cmd_master.sv
// Directed bench for alu_cmd_master with an out-beat scoreboard.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge
// or 1ns after the rising edge.
module tb_alu_cmd_master;

    logic       clk = 1'b0;
    logic       reset;
    logic       host_valid;
    logic       host_ready;
    logic [1:0] host_op;
    logic [3:0] host_a;
    logic [3:0] host_b;
    logic [9:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [8:0] rsp_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [8:0] out_result;
    logic [1:0] out_op;
    logic       out_mismatch;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] outstanding;
    logic       timeout_err;
    logic       proto_err;
    logic       mismatch_err;

    always #5 clk = ~clk;

    alu_cmd_master #(
        .MAX_OUTSTANDING (7),
        .TIMEOUT_CYCLES  (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .host_op      (host_op),
        .host_a       (host_a),
        .host_b       (host_b),
        .cmd_data     (cmd_data),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .rsp_data     (rsp_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .out_result   (out_result),
        .out_op       (out_op),
        .out_mismatch (out_mismatch),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .outstanding  (outstanding),
        .timeout_err  (timeout_err),
        .proto_err    (proto_err),
        .mismatch_err (mismatch_err)
    );

    typedef struct {
        logic [1:0] op;
        logic [8:0] res;
        logic       mm;
    } beat_t;

    beat_t sb_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic host_send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        bit got;
        got = 1'b0;
        host_valid = 1'b1;
        host_op    = op;
        host_a     = a;
        host_b     = b;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (host_ready) got = 1'b1;
        end
        if (got) begin
            @(posedge clk);
            #1;
        end
        host_valid = 1'b0;
        chk("host accepted", 32'(got), 32'd1);
    endtask

    task automatic send_rsp(input logic [8:0] data, input logic [1:0] eop,
                            input logic [8:0] eres, input logic emm);
        bit    got;
        beat_t e;
        got = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = data;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (rsp_ready) got = 1'b1;
        end
        if (got) begin
            e.op  = eop;
            e.res = eres;
            e.mm  = emm;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
        end
        rsp_valid = 1'b0;
        chk("rsp accepted", 32'(got), 32'd1);
    endtask

    // Monitor: every out transfer must match the oldest expected beat.
    always @(negedge clk) begin : monitor
        beat_t e;
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected out beat: result %0h op %0h, expected none", out_result, out_op);
            end else begin
                e = sb_q.pop_front();
                chk("out_result", 32'(out_result), 32'(e.res));
                chk("out_op", 32'(out_op), 32'(e.op));
                chk("out_mismatch", 32'(out_mismatch), 32'(e.mm));
            end
        end
    end

    initial begin : watchdog
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        host_valid = 1'b0;
        host_op    = '0;
        host_a     = '0;
        host_b     = '0;
        cmd_ready  = 1'b1;
        rsp_valid  = 1'b0;
        rsp_data   = '0;
        out_ready  = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst host_ready", 32'(host_ready), 32'd0);
        chk("rst rsp_ready", 32'(rsp_ready), 32'd0);
        chk("rst cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst cmd_data", 32'(cmd_data), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_result", 32'(out_result), 32'd0);
        chk("rst outstanding", 32'(outstanding), 32'd0);
        chk("rst errs", 32'({timeout_err, proto_err, mismatch_err}), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        chk("idle host_ready", 32'(host_ready), 32'd1);

        // Add 9+8
        host_send(2'd0, 4'd9, 4'd8);
        chk("add cmd_valid", 32'(cmd_valid), 32'd1);
        chk("add cmd_data", 32'(cmd_data), 32'h089);
        tick();
        chk("add outstanding", 32'(outstanding), 32'd1);
        send_rsp(9'd17, 2'd0, 9'd17, 1'b0);
        tick();
        chk("add drained", 32'(outstanding), 32'd0);

        // Sub wrap, then a wrong result
        host_send(2'd1, 4'd2, 4'd5);
        tick();
        send_rsp(9'h1FD, 2'd1, 9'h1FD, 1'b0);
        tick();
        chk("sub ok mismatch_err", 32'(mismatch_err), 32'd0);
        host_send(2'd1, 4'd2, 4'd5);
        tick();
        send_rsp(9'h003, 2'd1, 9'h003, 1'b1);
        tick();
        chk("sub bad mismatch_err", 32'(mismatch_err), 32'd1);
        chk("mismatch no fault", 32'(host_ready), 32'd1);

        // Mul, div, div by zero
        host_send(2'd2, 4'd7, 4'd6);
        tick();
        send_rsp(9'd42, 2'd2, 9'd42, 1'b0);
        host_send(2'd3, 4'd13, 4'd4);
        tick();
        send_rsp(9'd3, 2'd3, 9'd3, 1'b0);
        host_send(2'd3, 4'd5, 4'd0);
        tick();
        send_rsp(9'h1FF, 2'd3, 9'h1FF, 1'b0);
        tick(2);

        // Credit limit: seven issued, eighth held until a response returns
        for (int i = 0; i < 7; i++) host_send(2'd2, 4'(i), 4'd3);
        tick(2);
        chk("credit outstanding", 32'(outstanding), 32'd7);
        chk("credit host_ready", 32'(host_ready), 32'd0);
        host_valid = 1'b1;
        host_op    = 2'd2;
        host_a     = 4'd7;
        host_b     = 4'd3;
        tick(4);
        chk("credit 8th held", 32'(cmd_valid), 32'd0);
        chk("credit still 7", 32'(outstanding), 32'd7);
        send_rsp(9'd0, 2'd2, 9'd0, 1'b0);
        host_send(2'd2, 4'd7, 4'd3);
        chk("credit 8th cmd_data", 32'(cmd_data), 32'h237);
        tick();
        chk("credit refill", 32'(outstanding), 32'd7);
        for (int i = 1; i <= 7; i++) send_rsp(9'(3 * i), 2'd2, 9'(3 * i), 1'b0);
        tick();
        chk("credit drained", 32'(outstanding), 32'd0);

        // Cmd and response transfer in the same cycle
        host_send(2'd0, 4'd1, 4'd1);
        host_send(2'd0, 4'd2, 4'd2);
        host_send(2'd0, 4'd3, 4'd3);
        tick();
        chk("simul pre outstanding", 32'(outstanding), 32'd3);
        cmd_ready = 1'b0;
        host_send(2'd1, 4'd7, 4'd2);
        tick();
        chk("simul cmd pending", 32'(cmd_valid), 32'd1);
        rsp_valid = 1'b1;
        rsp_data  = 9'd2;
        cmd_ready = 1'b1;
        @(negedge clk);
        chk("simul rsp_ready", 32'(rsp_ready), 32'd1);
        sb_q.push_back('{op: 2'd0, res: 9'd2, mm: 1'b0});
        @(posedge clk);
        #1 rsp_valid = 1'b0;
        chk("simul outstanding", 32'(outstanding), 32'd3);
        chk("simul cmd sent", 32'(cmd_valid), 32'd0);
        send_rsp(9'd4, 2'd0, 9'd4, 1'b0);
        send_rsp(9'd6, 2'd0, 9'd6, 1'b0);
        send_rsp(9'd5, 2'd1, 9'd5, 1'b0);
        tick();
        chk("simul drained", 32'(outstanding), 32'd0);

        // Output backpressure
        host_send(2'd0, 4'd1, 4'd2);
        host_send(2'd0, 4'd3, 4'd4);
        tick();
        out_ready = 1'b0;
        send_rsp(9'd3, 2'd0, 9'd3, 1'b0);
        @(negedge clk);
        chk("bp rsp_ready", 32'(rsp_ready), 32'd0);
        chk("bp out_valid", 32'(out_valid), 32'd1);
        rsp_valid = 1'b1;
        rsp_data  = 9'd7;
        tick(3);
        chk("bp rsp_ready held", 32'(rsp_ready), 32'd0);
        chk("bp out_result held", 32'(out_result), 32'd3);
        chk("bp outstanding", 32'(outstanding), 32'd1);
        out_ready = 1'b1;
        sb_q.push_back('{op: 2'd0, res: 9'd7, mm: 1'b0});
        tick();
        rsp_valid = 1'b0;
        chk("bp second beat", 32'(out_result), 32'd7);
        chk("bp drained", 32'(outstanding), 32'd0);
        tick();

        // Reset mid-stream: held beat, outstanding tag and pending cmd all dropped
        host_send(2'd0, 4'd5, 4'd5);
        host_send(2'd0, 4'd6, 4'd6);
        tick();
        out_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = 9'd10;
        tick();
        rsp_valid = 1'b0;
        cmd_ready = 1'b0;
        host_send(2'd2, 4'd4, 4'd4);
        chk("mid pre out_valid", 32'(out_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid rst cmd_valid", 32'(cmd_valid), 32'd0);
        chk("mid rst cmd_data", 32'(cmd_data), 32'd0);
        chk("mid rst out_valid", 32'(out_valid), 32'd0);
        chk("mid rst out_result", 32'(out_result), 32'd0);
        chk("mid rst outstanding", 32'(outstanding), 32'd0);
        chk("mid rst readies", 32'({host_ready, rsp_ready}), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        cmd_ready = 1'b1;
        out_ready = 1'b1;
        tick(3);
        chk("mid post out_valid", 32'(out_valid), 32'd0);
        chk("mid post outstanding", 32'(outstanding), 32'd0);

        // Response while idle
        rsp_valid = 1'b1;
        rsp_data  = 9'd5;
        @(negedge clk);
        chk("proto rsp_ready", 32'(rsp_ready), 32'd1);
        @(posedge clk);
        #1 rsp_valid = 1'b0;
        chk("proto_err set", 32'(proto_err), 32'd1);
        chk("proto fault host_ready", 32'(host_ready), 32'd0);
        chk("proto outstanding", 32'(outstanding), 32'd0);
        tick();
        chk("proto no beat", 32'(out_valid), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("proto cleared", 32'(proto_err), 32'd0);
        chk("recovered host_ready", 32'(host_ready), 32'd1);

        // Timeout with one outstanding
        host_send(2'd0, 4'd1, 4'd1);
        tick();
        chk("to outstanding", 32'(outstanding), 32'd1);
        tick(63);
        chk("to not yet", 32'(timeout_err), 32'd0);
        tick();
        chk("to set", 32'(timeout_err), 32'd1);
        chk("to fault host_ready", 32'(host_ready), 32'd0);
        send_rsp(9'd2, 2'd0, 9'd2, 1'b0);
        tick();
        chk("to drained in fault", 32'(outstanding), 32'd0);
        chk("to sticky", 32'(timeout_err), 32'd1);

        tick(3);
        chk("scoreboard empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_cmd_master.md
ALU_CMD_MASTER -- requirements
Module: alu_cmd_master

Interface
REQ-001 The block SHALL have parameter MAX_OUTSTANDING, default 7, meaning the maximum number of commands issued and not yet answered (range 1..7).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the cycles without a response while commands are outstanding before a timeout fault.
REQ-003 clk  input  1  clock; all logic SHALL be on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 host_valid / host_ready  input / output  1 / 1  host request handshake.
REQ-006 host_op, host_a, host_b  input  2 / 4 / 4  opcode (0 add, 1 sub, 2 mul, 3 div), operand A, operand B.
REQ-007 cmd_data  output  10  packed command: [9:8] op, [7:4] B, [3:0] A.
REQ-008 cmd_valid / cmd_ready  output / input  1 / 1  command handshake toward the ALU path.
REQ-009 rsp_data, rsp_valid / rsp_ready  input, input / output  9, 1 / 1  result handshake from the ALU path.
REQ-010 out_result, out_op, out_mismatch, out_valid / out_ready  output, output, output, output / input  9, 2, 1, 1 / 1  checked result to host.
REQ-011 outstanding  output  3  count of issued, unanswered commands.
REQ-012 timeout_err, proto_err, mismatch_err  output  1 each  sticky fault flags.

Function
REQ-013 Transfers SHALL occur only in cycles where valid and ready are both high; a raised valid SHALL hold its data stable until the transfer.
REQ-014 host_ready SHALL equal (!cmd_valid || cmd_ready) && (outstanding < MAX_OUTSTANDING) && state != FAULT.
REQ-015 A host transfer SHALL register cmd_data = {host_op, host_b, host_a} and assert cmd_valid on the next cycle; latency host-to-cmd is 1 cycle.
REQ-016 Each cmd transfer SHALL push {op, B, A} into an internal 8-entry in-order tag queue and increment outstanding.
REQ-017 rsp_ready SHALL equal !out_valid || out_ready; a response transfer SHALL pop the tag queue and decrement outstanding.
REQ-018 A cmd transfer and a response transfer in the same cycle SHALL leave outstanding unchanged.
REQ-019 On a response, the block SHALL compute expected as 9-bit: add A+B zero-extended; sub (A-B) mod 512; mul A*B; div floor(A/B).
REQ-020 Division with B == 0 SHALL skip comparison (out_mismatch = 0).
REQ-021 One cycle after a response transfer, out_result = rsp_data, out_op = tagged op, out_mismatch = (rsp_data != expected), out_valid = 1, held until out_ready.
REQ-022 Any out_mismatch = 1 beat SHALL set mismatch_err.
REQ-023 A response transfer while outstanding == 0 SHALL set proto_err, be consumed, produce no out beat, and leave outstanding at 0.
REQ-024 A timer SHALL clear on every response transfer and whenever outstanding == 0, and increment otherwise; reaching TIMEOUT_CYCLES SHALL set timeout_err.
REQ-025 State machine: IDLE (outstanding == 0), ACTIVE (outstanding > 0), FAULT; IDLE<->ACTIVE follows outstanding; any of timeout_err or proto_err being set SHALL move to FAULT.
REQ-026 FAULT SHALL be exited only by reset; in FAULT, responses SHALL still be drained and checked, and a pending cmd_valid SHALL complete.
REQ-027 mismatch_err SHALL NOT cause FAULT.

Reset
REQ-028 Reset SHALL force cmd_valid, out_valid, out_mismatch, all error flags, outstanding, the timer, and the queue pointers to 0, and the state to IDLE.
REQ-029 During reset host_ready and rsp_ready SHALL be 0; cmd_data and out_result SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL discard all outstanding tags without generating out beats.

Structure
REQ-031 A shared package SHALL hold the opcode enum, the state enum, the field positions of cmd_data, and the 9-bit expected-result function.
REQ-032 The tag queue SHALL be one sub-module, alu_tag_queue (8 x 10-bit, push/pop, count).

Verification
REQ-033 Add: host sends op0 A=9 B=8, then response 17 -> cmd_data = 10'h089 one cycle later; out_result = 17, out_op = 0, out_mismatch = 0.
REQ-034 Sub wrap: op1 A=2 B=5, then response 9'h1FD -> out_mismatch = 0; a response of 9'h003 instead -> out_mismatch = 1 and mismatch_err = 1.
REQ-035 Credit limit: cmd_ready = 1, no responses, 8 host requests -> 7 issued, outstanding = 7, host_ready = 0 until 1 response, then 8th issued.
REQ-036 Simultaneous events: cmd transfer and response transfer in the same cycle with outstanding = 3 -> outstanding stays 3, and out beat op matches the oldest tag.
REQ-037 Faults: rsp_valid while idle -> proto_err = 1, FAULT, host_ready = 0; separately, 1 outstanding and no response for 64 cycles -> timeout_err = 1.
REQ-038 Backpressure/reset: out_ready = 0 with 2 responses pending -> rsp_ready = 0 after first beat and data held; reset mid-stream -> all outputs 0 next cycle.
